averager_reader: RTL

Readout engine for the averager accumulator BRAM. Once the averager counter reports a finished acquisition, the block reads words 0..count_max from the accumulator memory through the BRAM read port. It streams them in order on an AXI4-Stream master with full backpressure and marks the last word with tlast. It sits between the averager's accumulator BRAM read port and the DMA/stream path to the PS.

---
 rtl/averager_reader_pkg.sv | 11 +
 rtl/averager_reader_fifo.sv | 44 ++++
 rtl/averager_reader.sv | 113 +++++++++++
 3 files changed

// File: rtl/averager_reader_pkg.sv
// averager_reader_pkg: FSM state type and FIFO sizing helpers for the averager readout engine
package averager_reader_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_READY, READ, DRAIN} state_t;
  // Two slots beyond the read pipeline so a full in-flight window plus one held beat never stalls issue.
  function automatic int fifo_depth(input int lat);
    return lat + 2;
  endfunction
  function automatic int fifo_ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/averager_reader_fifo.sv
// averager_reader_fifo: synchronous first-word-fall-through FIFO, async active-high reset
//   clk, rst            clock, async reset
//   wr_en_i, wr_data_i  push side
//   rd_en_i, rd_data_o  pop side; rd_data_o shows the head entry whenever !empty_o
//   empty_o, count_o    occupancy
module averager_reader_fifo
  import averager_reader_pkg::*;
#(
  parameter int W = 33,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = fifo_ptr_w(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          wr, rd;
  assign rd = rd_en_i && cnt_q != '0;
  assign wr = wr_en_i && (cnt_q != CW'(DEPTH) || rd);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign rd_data_o = mem_q[rp_q];
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q] <= wr_data_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) wp_q <= wp_q == PW'(DEPTH - 1) ? '0 : wp_q + 1'b1;
      if (rd) rp_q <= rp_q == PW'(DEPTH - 1) ? '0 : rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(wr) - CW'(rd);
    end
endmodule

// File: rtl/averager_reader.sv
// averager_reader: streams accumulator BRAM words 0..count_max onto AXI4-Stream after an acquisition
//   clk, rst                 clock, async active-high reset
//   start, count_max         readout request and last word index (latched on accepted start)
//   avg_ready, n_avg         accumulator-stable flag and average count (captured when readout begins)
//   bram_addr/en/rdata       BRAM read port, byte addressed, BRAM_LATENCY read latency
//   m_axis_*                 stream master, tlast on the final word
//   busy, done, n_avg_out    status
// Optional feature macro AVERAGER_READER_HEADER_EN: prepend one header beat carrying n_avg.
module averager_reader
  import averager_reader_pkg::*;
#(
  parameter int FAST_COUNT_WIDTH = 13,
  parameter int SLOW_COUNT_WIDTH = 19,
  parameter int DATA_WIDTH = 32,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [FAST_COUNT_WIDTH-1:0] count_max,
  input  logic                        avg_ready,
  input  logic [SLOW_COUNT_WIDTH-1:0] n_avg,
  output logic [FAST_COUNT_WIDTH+1:0] bram_addr,
  output logic                        bram_en,
  input  logic [DATA_WIDTH-1:0]       bram_rdata,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        busy,
  output logic                        done,
  output logic [SLOW_COUNT_WIDTH-1:0] n_avg_out
);
  localparam int DEPTH = fifo_depth(BRAM_LATENCY);
  localparam int CW = $clog2(DEPTH + 1);
  state_t                      state_q, state_d;
  logic [FAST_COUNT_WIDTH-1:0] cmax_q, idx_q;
  logic [SLOW_COUNT_WIDTH-1:0] n_avg_q;
  logic                        done_q;
  logic [BRAM_LATENCY-1:0]     vld_q, lst_q;
  logic [CW-1:0]               fcnt;
  logic                        fempty, credit, issue, is_last, hs, fin, wr_en;
  logic [DATA_WIDTH:0]         wr_data, rd_data;
  int                          in_flight;
  // Credit covers reads still in the BRAM pipeline, so returning data always has a free slot.
  assign in_flight = $countones(vld_q);
  assign credit = in_flight + int'(fcnt) < DEPTH;
  assign issue = state_q == READ && credit;
  assign is_last = idx_q == cmax_q;
  assign hs = !fempty && m_axis_tready;
  assign fin = state_q == DRAIN && in_flight == 0 && hs && rd_data[DATA_WIDTH];
`ifdef AVERAGER_READER_HEADER_EN
  // Header is pushed on entry to READ; the read pipeline is empty then, so the write port is free.
  assign wr_en = vld_q[BRAM_LATENCY-1] || (state_q == WAIT_READY && avg_ready);
  assign wr_data = vld_q[BRAM_LATENCY-1] ? {lst_q[BRAM_LATENCY-1], bram_rdata} : {1'b0, DATA_WIDTH'(n_avg)};
`else
  assign wr_en = vld_q[BRAM_LATENCY-1];
  assign wr_data = {lst_q[BRAM_LATENCY-1], bram_rdata};
`endif
  averager_reader_fifo #(
    .W(DATA_WIDTH + 1),
    .DEPTH(DEPTH),
    .CW(CW)
  ) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en_i(wr_en),
    .wr_data_i(wr_data),
    .rd_en_i(m_axis_tready),
    .rd_data_o(rd_data),
    .empty_o(fempty),
    .count_o(fcnt)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = start ? WAIT_READY : IDLE;
      WAIT_READY: state_d = avg_ready ? READ : WAIT_READY;
      READ:       state_d = issue && is_last ? DRAIN : READ;
      DRAIN:      state_d = fin ? IDLE : DRAIN;
      default:    state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cmax_q  <= '0;
      idx_q   <= '0;
      n_avg_q <= '0;
      done_q  <= 1'b0;
      vld_q   <= '0;
      lst_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= fin;
      vld_q   <= BRAM_LATENCY'({vld_q, issue});
      lst_q   <= BRAM_LATENCY'({lst_q, issue && is_last});
      if (state_q == IDLE && start) begin
        cmax_q <= count_max;
        idx_q  <= '0;
      end
      if (issue) idx_q <= idx_q + 1'b1;
      if (state_q == WAIT_READY && avg_ready) n_avg_q <= n_avg;
    end
  assign bram_en = issue;
  assign bram_addr = {idx_q, 2'b00};
  assign m_axis_tvalid = !fempty;
  assign m_axis_tdata = fempty ? '0 : rd_data[DATA_WIDTH-1:0];
  assign m_axis_tlast = !fempty && rd_data[DATA_WIDTH];
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign n_avg_out = n_avg_q;
endmodule
